// File: rtl/data_memory_model.sv
// rtl/data_memory_model.sv - line-granular data memory with fixed request-to-ack latency
//
// Purpose:
//   Models the backing memory behind the dcache controller. One request at a
//   time is accepted in IDLE, waits LATENCY cycles in BUSY, then pulses ack_o
//   for one cycle in ACK. Reads and writes move a whole 256-bit line.
//
// Parameters:
//   LATENCY     cycles from request acceptance to ack (1..255)
//   DEPTH_LOG2  log2 of the number of 256-bit lines
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-low reset (does not clear the line array)
//   enable_i   request valid
//   write_i    1 = line write, 0 = line read
//   addr_i     byte address; bits [4:0] and bits above DEPTH_LOG2+4 are ignored
//   data_i     write line data
//   ack_o      one-cycle completion pulse
//   data_o     registered read line data, held until the next read completes
//   rd_cnt_o   completed-read counter (wraps)
//   wr_cnt_o   completed-write counter (wraps)

module data_memory_model #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic [15:0]  rd_cnt_o,
    output logic [15:0]  wr_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);

    logic [1:0]            r_state;
    logic [7:0]            r_lat_cnt;
    logic                  r_write;
    logic [DEPTH_LOG2-1:0] r_line;
    logic [255:0]          r_wdata;
    logic [255:0]          r_data_o;
    logic [15:0]           r_rd_cnt;
    logic [15:0]           r_wr_cnt;

    // Line storage is deliberately outside the reset domain so its contents
    // survive rst_i.
    logic [255:0]          r_mem [DEPTH];

    logic                  w_done;
    logic                  w_unused_addr;

    // Last BUSY edge: the request completes and the FSM moves to ACK.
    assign w_done = (r_state == S_BUSY) && (r_lat_cnt == LAT_LAST);

    // Offset and alias bits of the address have no function.
    assign w_unused_addr = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= 8'd0;
            r_write   <= 1'b0;
            r_line    <= '0;
            r_wdata   <= '0;
            r_data_o  <= '0;
            r_rd_cnt  <= 16'd0;
            r_wr_cnt  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable_i) begin
                        r_state   <= S_BUSY;
                        r_lat_cnt <= 8'd0;
                        r_write   <= write_i;
                        r_line    <= addr_i[DEPTH_LOG2+4:5];
                        r_wdata   <= data_i;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_state <= S_ACK;
                        if (r_write) begin
                            r_wr_cnt <= r_wr_cnt + 16'd1;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 16'd1;
                            r_data_o <= r_mem[r_line];
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 8'd1;
                    end
                end
                // ACK always returns to IDLE; enable_i is not looked at here,
                // which guarantees one IDLE turnaround cycle between requests.
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // w_done is false while in reset (state is forced to IDLE), so a request
    // interrupted by reset never reaches the array.
    always_ff @(posedge clk_i) begin
        if (w_done && r_write) begin
            r_mem[r_line] <= r_wdata;
        end
    end

    assign ack_o    = (r_state == S_ACK);
    assign data_o   = r_data_o;
    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;

endmodule

// File: tb/tb_data_memory_model.sv
// tb/tb_data_memory_model.sv - self-checking bench for data_memory_model

module tb_data_memory_model;

    localparam int LAT0 = 10;
    localparam int LAT1 = 1;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         en   [2];
    logic         wr   [2];
    logic [31:0]  addr [2];
    logic [255:0] din  [2];
    logic         ack  [2];
    logic [255:0] dout [2];
    logic [15:0]  rdc  [2];
    logic [15:0]  wrc  [2];

    data_memory_model #(.LATENCY(LAT0), .DEPTH_LOG2(9)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(en[0]), .write_i(wr[0]),
        .addr_i(addr[0]), .data_i(din[0]), .ack_o(ack[0]), .data_o(dout[0]),
        .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0])
    );

    data_memory_model #(.LATENCY(LAT1), .DEPTH_LOG2(9)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(en[1]), .write_i(wr[1]),
        .addr_i(addr[1]), .data_i(din[1]), .ack_o(ack[1]), .data_o(dout[1]),
        .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1])
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: line contents keyed by dut*1024 + line index.
    logic [255:0] m_mem [int];
    logic [15:0]  m_rd   [2];
    logic [15:0]  m_wr   [2];
    logic [255:0] m_dout [2];

    typedef struct {
        bit           w;
        logic [31:0]  a;
        logic [255:0] d;
        logic [255:0] exp_dout;
        logic [15:0]  exp_rd;
        logic [15:0]  exp_wr;
    } vec_t;

    vec_t tbl [7];

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int key(input int d, input logic [31:0] a);
        return d * 1024 + int'((a >> 5) & 32'h1FF);
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input int d, input string tag);
        chk($sformatf("%s_ack%0d", tag, d),   256'(ack[d]), 256'(0));
        chk($sformatf("%s_dout%0d", tag, d),  dout[d],      256'(0));
        chk($sformatf("%s_rdcnt%0d", tag, d), 256'(rdc[d]), 256'(0));
        chk($sformatf("%s_wrcnt%0d", tag, d), 256'(wrc[d]), 256'(0));
    endtask

    // One request from an IDLE DUT. hold keeps enable_i high through BUSY,
    // scramble randomises all request inputs after acceptance.
    task automatic req(input int d, input bit w, input logic [31:0] a,
                       input logic [255:0] dat, input bit hold, input bit scramble);
        int n;
        bit seen;
        int k;
        @(negedge clk_i);
        en[d] = 1'b1; wr[d] = w; addr[d] = a; din[d] = dat;
        @(posedge clk_i);
        n = 0;
        seen = 1'b0;
        while (!seen && n <= lat_of(d) + 3) begin
            @(negedge clk_i);
            if (!hold) en[d] = 1'b0;
            if (scramble) begin
                addr[d] = $urandom;
                din[d]  = rand256();
                wr[d]   = 1'($urandom_range(0, 1));
            end
            if (ack[d] === 1'b1) seen = 1'b1;
            else n++;
        end
        en[d] = 1'b0;
        k = key(d, a);
        if (w) begin
            m_mem[k] = dat;
            m_wr[d]  = m_wr[d] + 16'd1;
        end else begin
            m_rd[d] = m_rd[d] + 16'd1;
            if (m_mem.exists(k)) m_dout[d] = m_mem[k];
        end
        chk($sformatf("ack_latency%0d_a%h", d, a), 256'(n), 256'(lat_of(d)));
        chk($sformatf("rd_cnt%0d", d), 256'(rdc[d]), 256'(m_rd[d]));
        chk($sformatf("wr_cnt%0d", d), 256'(wrc[d]), 256'(m_wr[d]));
        chk($sformatf("data_o%0d_a%h", d, a), dout[d], m_dout[d]);
        @(negedge clk_i);
        chk($sformatf("ack_one_cycle%0d", d), 256'(ack[d]), 256'(0));
    endtask

    initial begin
        logic [255:0] pat_a5;
        logic [255:0] pat_p;
        logic [255:0] pat_3c;
        logic [255:0] h1;
        logic [255:0] h2;
        int           first;
        int           second;
        int           j;
        int           extra;
        int           lines [6];

        pat_a5 = {32{8'hA5}};
        pat_p  = {4{64'h0123456789ABCDEF}};
        pat_3c = {32{8'h3C}};
        lines  = '{3, 5, 32, 100, 511, 0};

        tbl[0] = '{1'b1, 32'h0000_0060, pat_a5, 256'(0), 16'd0, 16'd1};
        tbl[1] = '{1'b0, 32'h0000_0060, 256'(0), pat_a5, 16'd1, 16'd1};
        tbl[2] = '{1'b1, 32'h0000_0400, pat_p,  pat_a5, 16'd1, 16'd2};
        tbl[3] = '{1'b0, 32'h0000_041C, 256'(0), pat_p,  16'd2, 16'd2};
        tbl[4] = '{1'b0, 32'h0000_4060, 256'(0), pat_a5, 16'd3, 16'd2};
        tbl[5] = '{1'b1, 32'hFFFF_C07F, pat_3c, pat_a5, 16'd3, 16'd3};
        tbl[6] = '{1'b0, 32'h0000_0060, 256'(0), pat_3c, 16'd4, 16'd3};

        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; din[d] = '0;
            m_rd[d] = '0; m_wr[d] = '0; m_dout[d] = '0;
        end

        // Reset values
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_reset_state(0, "reset");
        chk_reset_state(1, "reset");
        rst_i = 1'b1;

        // Directed vectors: latency, write-then-read, alias
        for (int i = 0; i < 7; i++) begin
            req(0, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_dout", i),  dout[0],      tbl[i].exp_dout);
            chk($sformatf("tbl%0d_rdcnt", i), 256'(rdc[0]), 256'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d_wrcnt", i), 256'(wrc[0]), 256'(tbl[i].exp_wr));
        end

        // Enable held high across two writes
        h1 = rand256();
        h2 = rand256();
        @(negedge clk_i);
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0800; din[0] = h1;
        first = -1;
        second = -1;
        j = 0;
        @(posedge clk_i);
        while (second < 0 && j < 3 * LAT0 + 10) begin
            @(negedge clk_i);
            if (ack[0] === 1'b1) begin
                if (first < 0) begin
                    first = j;
                    addr[0] = 32'h0000_0A00;
                    din[0]  = h2;
                end else begin
                    second = j;
                    en[0] = 1'b0;
                end
            end
            j++;
        end
        en[0] = 1'b0;
        chk("held_first_ack", 256'(first), 256'(LAT0));
        chk("held_second_ack", 256'(second), 256'(2 * LAT0 + 2));
        m_mem[key(0, 32'h800)] = h1;
        m_mem[key(0, 32'hA00)] = h2;
        m_wr[0] = m_wr[0] + 16'd2;
        extra = 0;
        repeat (LAT0 + 4) begin
            @(negedge clk_i);
            if (ack[0] === 1'b1) extra++;
        end
        chk("held_no_extra_ack", 256'(extra), 256'(0));
        chk("held_wr_cnt", 256'(wrc[0]), 256'(m_wr[0]));
        req(0, 1'b0, 32'h0000_0800, '0, 1'b0, 1'b0);
        req(0, 1'b0, 32'h0000_0A00, '0, 1'b0, 1'b0);

        // Inputs scrambled and enable dropped during BUSY
        req(0, 1'b0, 32'h0000_041C, '0, 1'b0, 1'b1);
        req(0, 1'b1, 32'h0000_0A00, pat_3c, 1'b1, 1'b1);
        req(0, 1'b0, 32'h0000_0A00, '0, 1'b0, 1'b0);

        // Reset in the middle of a write to line 5
        req(0, 1'b1, 32'h0000_00A0, {32{8'h55}}, 1'b0, 1'b0);
        @(negedge clk_i);
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_00A0; din[0] = {32{8'hAA}};
        @(posedge clk_i);
        repeat (4) @(negedge clk_i);
        en[0] = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_reset_state(0, "midop_in_reset");
        rst_i = 1'b1;
        extra = 0;
        repeat (LAT0 + 5) begin
            @(negedge clk_i);
            if (ack[0] === 1'b1) extra++;
        end
        chk("midop_no_ack", 256'(extra), 256'(0));
        chk_reset_state(0, "midop_after");
        for (int d = 0; d < 2; d++) begin
            m_rd[d] = '0; m_wr[d] = '0; m_dout[d] = '0;
        end
        req(0, 1'b0, 32'h0000_00A0, '0, 1'b0, 1'b0);
        chk("midop_line5_kept", dout[0], {32{8'h55}});

        // Randomised traffic against the model
        for (int i = 0; i < 40; i++) begin
            int           li;
            logic [31:0]  a;
            bit           w;
            li = lines[$urandom_range(0, 5)];
            a  = ($urandom & 32'hFFFF_C000) | (32'(li) << 5) | ($urandom & 32'h1F);
            w  = m_mem.exists(key(0, a)) ? 1'($urandom_range(0, 1)) : 1'b1;
            req(0, w, a, rand256(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        // LATENCY = 1
        h1 = rand256();
        req(1, 1'b1, 32'h1234_5660, h1, 1'b0, 1'b0);
        req(1, 1'b0, 32'h0000_1660, '0, 1'b0, 1'b0);
        chk("lat1_readback", dout[1], h1);

        // Write counter wrap from 0xFFFF
        @(negedge clk_i);
        force u_dut1.r_wr_cnt = 16'hFFFF;
        @(negedge clk_i);
        release u_dut1.r_wr_cnt;
        m_wr[1] = 16'hFFFF;
        #1;
        chk("wrap_preset", 256'(wrc[1]), 256'(16'hFFFF));
        req(1, 1'b1, 32'h0000_0020, rand256(), 1'b0, 1'b0);
        chk("wrap_to_zero", 256'(wrc[1]), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_model.md
DATA_MEMORY_MODEL -- requirements
Module: data_memory_model

Interface
REQ-001 Parameter LATENCY, default 10, meaning cycles from request acceptance to ack; legal range 1..255.
REQ-002 Parameter DEPTH_LOG2, default 9, meaning log2 of the number of 256-bit lines (default 512 lines).
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 enable_i  input  1  request valid from the dcache controller.
REQ-006 write_i  input  1  request type: 1 = line write, 0 = line read.
REQ-007 addr_i  input  32  byte address of the line.
REQ-008 data_i  input  256  write line data.
REQ-009 ack_o  output  1  one-cycle completion pulse.
REQ-010 data_o  output  256  read line data, registered.
REQ-011 rd_cnt_o  output  16  completed-read counter.
REQ-012 wr_cnt_o  output  16  completed-write counter.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, BUSY, ACK.
REQ-014 In IDLE with enable_i=1 at a rising edge, the block SHALL capture addr_i, data_i, write_i, clear the latency counter to 0, and enter BUSY.
REQ-015 In IDLE with enable_i=0, the block SHALL remain in IDLE with no side effects.
REQ-016 In BUSY, an 8-bit latency counter SHALL increment each edge until it equals LATENCY-1; on that edge the FSM SHALL enter ACK.
REQ-017 ack_o SHALL be 1 exactly while in ACK, i.e., during the cycle following edge t+LATENCY, where t is the acceptance edge.
REQ-018 On the BUSY->ACK edge, a captured write SHALL store the captured data into line addr[DEPTH_LOG2+4:5]; a captured read SHALL load that line into data_o.
REQ-019 Address bits [4:0] SHALL be ignored; bits above DEPTH_LOG2+4 SHALL be ignored, so addresses alias modulo the array size.
REQ-020 data_o SHALL hold its value until the next read completes; writes SHALL NOT change data_o.
REQ-021 ACK SHALL always transition to IDLE on the next edge, regardless of enable_i; no request is accepted in the ACK cycle.
REQ-022 A new request SHALL be accepted at the earliest on the edge that ends the first IDLE cycle after ACK (one turnaround cycle minimum).
REQ-023 Changes on enable_i, write_i, addr_i, or data_i during BUSY or ACK SHALL be ignored; deassertion of enable_i during BUSY SHALL NOT abort the request.
REQ-024 rd_cnt_o or wr_cnt_o SHALL increment by 1 on each completed read or write, respectively, on the BUSY->ACK edge.
REQ-025 rd_cnt_o and wr_cnt_o SHALL wrap from 0xFFFF to 0x0000.
REQ-026 A read of a line written earlier SHALL return the most recently written 256-bit value.
REQ-027 A read of a never-written line SHALL return the initial array contents, which the bench loads by $readmemb/backdoor.

Reset
REQ-028 While rst_i=0, the block SHALL hold the FSM in IDLE, the latency counter at 0, ack_o=0, data_o=0, rd_cnt_o=0, and wr_cnt_o=0.
REQ-029 Reset asserted during BUSY or ACK SHALL abandon the request: no array write, no counter increment, and no ack after release.
REQ-030 Reset SHALL NOT clear the memory array.
REQ-031 After rst_i deasserts, the first rising edge with enable_i=1 SHALL be accepted normally.

Verification
REQ-032 Read latency: LATENCY=10, backdoor line 3 = 256'hA5..A5, read addr 0x00000060 accepted at edge t -> ack_o=1 only in the cycle after edge t+10, data_o=256'hA5..A5, rd_cnt_o=1.
REQ-033 Write-then-read: write 256'h0123..CDEF to addr 0x00000400 (line 32), then read addr 0x0000041C -> same data returned, wr_cnt_o=1, rd_cnt_o=1.
REQ-034 Held enable: enable_i held high continuously across two writes -> exactly one ack per request, with at least one IDLE cycle between ack pulses, and no duplicate write.
REQ-035 Ignore/alias: drop enable_i in BUSY and change addr_i -> original request completes. Separately, access addr 0x00004060 -> hits line 3 (alias).
REQ-036 Reset mid-op: assert rst_i during BUSY of a write to line 5 -> ack_o never pulses, line 5 unchanged, counters 0, data_o 0.
REQ-037 Boundaries: LATENCY=1 -> ack in the cycle after edge t+1. Counters preset by 65535 completed writes, plus one more write -> wr_cnt_o=0x0000.
